target_net_mem_scheduler: RTL and testbench
===========================================

// Module: target_net_mem_scheduler
// PURPOSE
//  Sequences one target-net layer memory. Three requesters share that memory's single command port (enable/rw/update_weight/addr):
//  - the forward-pass reader, which sweeps every node of the layer;
//  - the layer-output writer, which writes single data words;
//  - the weight-sync engine, which copies main-net weights and bias into the target net node by node.
//  The block arbitrates between them, generates addresses and returns read results tagged with valid/last.
// PARAMETERS
//  DATA_WIDTH         32  width of one data/bias word
//  MEM_WIDTH          5   address width; 2**MEM_WIDTH >= NODE_WIDTH_CURRENT
//  NODE_WIDTH_CURRENT 32  nodes in this layer (sweep/sync length)
//  NODE_WIDTH_PREV    2   nodes in previous layer; weight bus = DATA_WIDTH*NODE_WIDTH_PREV
// PORTS
//  clk             in   1                      clock; all logic on posedge
//  rst_n           in   1                      asynchronous reset, active low
//  i_rd_req        in   1                      level request for a full read sweep; hold until o_rd_done
//  o_rd_done       out  1                      1-cycle pulse, same cycle as final o_rd_valid
//  o_rd_valid      out  1                      memory read data is valid this cycle
//  o_rd_last       out  1                      with o_rd_valid, this is node NODE_WIDTH_CURRENT-1
//  o_rd_addr       out  MEM_WIDTH              node index of the current o_rd_valid beat
//  i_wr_valid      in   1                      layer-output data write request
//  o_wr_ready      out  1                      write accepted when i_wr_valid & o_wr_ready
//  i_wr_addr       in   MEM_WIDTH              data write address
//  i_wr_data       in   DATA_WIDTH             data write value
//  o_wr_err        out  1                      1-cycle pulse: accepted write had addr >= NODE_WIDTH_CURRENT; write dropped
//  i_sync_req      in   1                      level request for a weight sync; hold until o_sync_done
//  i_sync_valid    in   1                      sync beat valid (one node per beat, in order 0..N-1)
//  o_sync_ready    out  1                      beat accepted when i_sync_valid & o_sync_ready
//  i_sync_weight   in   DATA_WIDTH*NODE_WIDTH_PREV  weights of the current node
//  i_sync_bias     in   DATA_WIDTH             bias of the current node
//  o_sync_done     out  1                      1-cycle pulse, cycle after the last beat is written
//  o_mem_enable    out  1                      to memory i_mem_enable
//  o_rw_mem        out  1                      to memory i_rw_mem; 1=read, 0=write
//  o_update_weight out  1                      to memory i_update_weight
//  o_mem_addr      out  MEM_WIDTH              to memory i_addr
//  o_mem_data      out  DATA_WIDTH             to memory i_data
//  o_mem_weight    out  DATA_WIDTH*NODE_WIDTH_PREV  to memory i_weight
//  o_mem_bias      out  DATA_WIDTH             to memory i_bias
//  o_busy          out  1                      state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, every output 0. Reset mid-operation aborts and returns to IDLE; no done pulse is issued.
//  - All memory command outputs are registered. o_mem_enable=0 in any cycle with no command.
//  - FSM states: IDLE, SYNC, WRITE, READ.
//  - IDLE priority when several requests are pending: i_sync_req > i_wr_valid > i_rd_req. Granted operations are never pre-empted.
//  - READ: cnt runs 0..NODE_WIDTH_CURRENT-1, one read command per cycle (enable=1, rw=1, addr=cnt).
//    - Memory read latency is 1 cycle, so o_rd_valid/o_rd_addr/o_rd_last lag the command by 1 cycle.
//    - After the last command the FSM spends 1 drain cycle, emitting the final valid, o_rd_last and o_rd_done, then returns to IDLE.
//    - A sweep always has N beats with no gaps and takes N+1 cycles from grant to IDLE.
//  - WRITE: i_wr_valid & o_wr_ready in IDLE captures addr/data. Next cycle issues enable=1, rw=0, update_weight=0, then returns to IDLE.
//    - o_wr_ready = (state==IDLE) & !i_sync_req.
//    - An out-of-range address gives no memory command and pulses o_wr_err.
//  - SYNC: o_sync_ready=1 only in SYNC. Each accepted beat issues enable=1, rw=0, update_weight=1, addr=cnt next cycle; cnt increments.
//    - i_sync_valid low stalls with no command issued.
//    - After beat N-1 is accepted: o_sync_ready drops, then o_sync_done pulses and the FSM returns to IDLE.
//  - Counter: MEM_WIDTH bits. Terminal compare is against NODE_WIDTH_CURRENT-1; the counter never wraps. It is cleared on entry to READ/SYNC.
//  - Requests dropped early: if i_rd_req or i_sync_req deasserts mid-operation, the operation still completes.
// STRUCTURE
//  - target_net_pkg holds:
//    - state localparams (IDLE=0, SYNC=1, WRITE=2, READ=3);
//    - layer codes (HIDDEN_1=1, HIDDEN_2=2, OUTPUT=3);
//    - the default DATA_WIDTH.
//  - One sub-module, target_net_node_counter: load-zero, enable, terminal flag at NODE_WIDTH_CURRENT-1. It is shared by READ and SYNC.
// TESTING
//  - Reset during READ at cnt=5 -> all outputs 0 next cycle; after release o_busy=0 and no o_rd_done.
//  - i_rd_req with N=4 -> read commands at addr 0,1,2,3 on consecutive cycles; o_rd_valid for 4 cycles lagging by 1; o_rd_last and o_rd_done with addr 3.
//  - i_sync_req with beats valid on cycles 0,1,3,4 (gap at 2), N=4 -> 4 update_weight writes at addr 0..3, no command in the gap, o_sync_done once.
//  - i_wr_valid addr=7, data=0x3F800000 -> one cycle later enable=1, rw=0, update_weight=0, addr=7, data=0x3F800000. With addr=N: no command, o_wr_err=1.
//  - i_sync_req, i_wr_valid and i_rd_req asserted together in IDLE -> SYNC first, then WRITE, then READ. o_wr_ready stays 0 until the sync is done.
//  - i_wr_valid asserted during READ -> o_wr_ready=0 for the whole sweep; the write is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/target_net_pkg.sv
// Shared definitions for the target-net layer memory scheduler: FSM state codes,
// layer identifiers and the default word width.
package target_net_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SYNC  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t READ  = 2'd3;

  localparam logic [1:0] HIDDEN_1 = 2'd1;
  localparam logic [1:0] HIDDEN_2 = 2'd2;
  localparam logic [1:0] OUTPUT   = 2'd3;
endpackage

// File: rtl/target_net_node_counter.sv
// Node index counter shared by the read sweep and the weight sync.
// Saturates at NODE_WIDTH_CURRENT-1 instead of wrapping.
module target_net_node_counter #(
  parameter int MEM_WIDTH          = 5,
  parameter int NODE_WIDTH_CURRENT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  output logic [MEM_WIDTH-1:0] cnt,
  output logic                 last
);
  localparam logic [MEM_WIDTH-1:0] LAST_ADDR = MEM_WIDTH'(NODE_WIDTH_CURRENT - 1);

  assign last = (cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + MEM_WIDTH'(1);
    end
  end
endmodule

// File: rtl/target_net_mem_scheduler.sv
// Arbitrates the single command port of a target-net layer memory between the
// weight-sync engine, the layer-output writer and the forward-pass reader.
module target_net_mem_scheduler
  import target_net_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int MEM_WIDTH          = 5,
  parameter int NODE_WIDTH_CURRENT = 32,
  parameter int NODE_WIDTH_PREV    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_rd_req,
  output logic                                  o_rd_done,
  output logic                                  o_rd_valid,
  output logic                                  o_rd_last,
  output logic [MEM_WIDTH-1:0]                  o_rd_addr,
  input  logic                                  i_wr_valid,
  output logic                                  o_wr_ready,
  input  logic [MEM_WIDTH-1:0]                  i_wr_addr,
  input  logic [DATA_WIDTH-1:0]                 i_wr_data,
  output logic                                  o_wr_err,
  input  logic                                  i_sync_req,
  input  logic                                  i_sync_valid,
  output logic                                  o_sync_ready,
  input  logic [DATA_WIDTH*NODE_WIDTH_PREV-1:0] i_sync_weight,
  input  logic [DATA_WIDTH-1:0]                 i_sync_bias,
  output logic                                  o_sync_done,
  output logic                                  o_mem_enable,
  output logic                                  o_rw_mem,
  output logic                                  o_update_weight,
  output logic [MEM_WIDTH-1:0]                  o_mem_addr,
  output logic [DATA_WIDTH-1:0]                 o_mem_data,
  output logic [DATA_WIDTH*NODE_WIDTH_PREV-1:0] o_mem_weight,
  output logic [DATA_WIDTH-1:0]                 o_mem_bias,
  output logic                                  o_busy
);
  localparam int WW = DATA_WIDTH * NODE_WIDTH_PREV;
  localparam logic [MEM_WIDTH-1:0] LAST_ADDR = MEM_WIDTH'(NODE_WIDTH_CURRENT - 1);
  localparam logic [MEM_WIDTH:0]   NODE_LIM  = (MEM_WIDTH+1)'(NODE_WIDTH_CURRENT);

  state_t                 state, state_d;
  logic                   drain, drain_d;
  logic [MEM_WIDTH-1:0]   cnt;
  logic                   cnt_last, cnt_clear, cnt_en;
  logic                   sync_accept, wr_in_range, rd_beat;
  logic                   cmd_en, cmd_rw, cmd_upd, wr_err_d, sync_done_d;
  logic [MEM_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_data, cmd_bias;
  logic [WW-1:0]          cmd_weight;

  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign o_wr_ready   = rst_n && (state == IDLE) && !i_sync_req;
  assign o_sync_ready = (state == SYNC) && !drain;
  assign o_busy       = (state != IDLE);
  assign sync_accept  = o_sync_ready && i_sync_valid;
  assign wr_in_range  = ({1'b0, i_wr_addr} < NODE_LIM);
  assign rd_beat      = o_mem_enable && o_rw_mem;
  assign cnt_clear    = (state == IDLE);
  assign cnt_en       = ((state == READ) && !drain) || sync_accept;

  target_net_node_counter #(
    .MEM_WIDTH         (MEM_WIDTH),
    .NODE_WIDTH_CURRENT(NODE_WIDTH_CURRENT)
  ) u_node_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(cnt_clear),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      drain <= 1'b0;
    end else begin
      state <= state_d;
      drain <= drain_d;
    end
  end

  // drain marks the closing cycle of READ/SYNC, once the last node has been issued.
  always_comb begin
    state_d = state;
    drain_d = 1'b0;
    case (state)
      IDLE: begin
        if (i_sync_req)      state_d = SYNC;
        else if (i_wr_valid) state_d = WRITE;
        else if (i_rd_req)   state_d = READ;
      end
      SYNC: begin
        if (drain) state_d = IDLE;
        drain_d = drain ? 1'b0 : (sync_accept && cnt_last);
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (drain) state_d = IDLE;
        drain_d = !drain && cnt_last;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next memory command; the read sweep pre-issues address 0 at grant so that
  // the visible command address tracks cnt during READ.
  always_comb begin
    cmd_en      = 1'b0;
    cmd_rw      = 1'b0;
    cmd_upd     = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    cmd_weight  = '0;
    cmd_bias    = '0;
    wr_err_d    = 1'b0;
    sync_done_d = (state == SYNC) && drain;
    case (state)
      IDLE: begin
        if (i_sync_req) begin
          cmd_en = 1'b0;
        end else if (i_wr_valid) begin
          if (wr_in_range) begin
            cmd_en   = 1'b1;
            cmd_addr = i_wr_addr;
            cmd_data = i_wr_data;
          end else begin
            wr_err_d = 1'b1;
          end
        end else if (i_rd_req) begin
          cmd_en = 1'b1;
          cmd_rw = 1'b1;
        end
      end
      SYNC: begin
        if (sync_accept) begin
          cmd_en     = 1'b1;
          cmd_upd    = 1'b1;
          cmd_addr   = cnt;
          cmd_weight = i_sync_weight;
          cmd_bias   = i_sync_bias;
        end
      end
      READ: begin
        if (!drain && !cnt_last) begin
          cmd_en   = 1'b1;
          cmd_rw   = 1'b1;
          cmd_addr = cnt + MEM_WIDTH'(1);
        end
      end
      default: cmd_en = 1'b0;
    endcase
  end

  // Read results lag the read command by the one-cycle memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mem_enable    <= 1'b0;
      o_rw_mem        <= 1'b0;
      o_update_weight <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_data      <= '0;
      o_mem_weight    <= '0;
      o_mem_bias      <= '0;
      o_wr_err        <= 1'b0;
      o_sync_done     <= 1'b0;
      o_rd_valid      <= 1'b0;
      o_rd_addr       <= '0;
      o_rd_last       <= 1'b0;
      o_rd_done       <= 1'b0;
    end else begin
      o_mem_enable    <= cmd_en;
      o_rw_mem        <= cmd_rw;
      o_update_weight <= cmd_upd;
      o_mem_addr      <= cmd_addr;
      o_mem_data      <= cmd_data;
      o_mem_weight    <= cmd_weight;
      o_mem_bias      <= cmd_bias;
      o_wr_err        <= wr_err_d;
      o_sync_done     <= sync_done_d;
      o_rd_valid      <= rd_beat;
      o_rd_addr       <= rd_beat ? o_mem_addr : '0;
      o_rd_last       <= rd_beat && (o_mem_addr == LAST_ADDR);
      o_rd_done       <= rd_beat && (o_mem_addr == LAST_ADDR);
    end
  end
endmodule

// File: tb/tb_target_net_mem_scheduler.sv
// Bench for target_net_mem_scheduler with an 8-node layer: command/read-result
// scoreboard plus cycle-exact sequences for reset, sweep, sync gaps and priority.
module tb_target_net_mem_scheduler;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int N  = 8;
  localparam int NP = 2;

  logic clk, rst_n;
  logic i_rd_req, o_rd_done, o_rd_valid, o_rd_last;
  logic [MW-1:0] o_rd_addr;
  logic i_wr_valid, o_wr_ready, o_wr_err;
  logic [MW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic i_sync_req, i_sync_valid, o_sync_ready, o_sync_done;
  logic [DW*NP-1:0] i_sync_weight, o_mem_weight;
  logic [DW-1:0] i_sync_bias, o_mem_data, o_mem_bias;
  logic o_mem_enable, o_rw_mem, o_update_weight, o_busy;
  logic [MW-1:0] o_mem_addr;

  target_net_mem_scheduler #(
    .DATA_WIDTH(DW), .MEM_WIDTH(MW), .NODE_WIDTH_CURRENT(N), .NODE_WIDTH_PREV(NP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_req(i_rd_req), .o_rd_done(o_rd_done), .o_rd_valid(o_rd_valid),
    .o_rd_last(o_rd_last), .o_rd_addr(o_rd_addr),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_wr_err(o_wr_err),
    .i_sync_req(i_sync_req), .i_sync_valid(i_sync_valid), .o_sync_ready(o_sync_ready),
    .i_sync_weight(i_sync_weight), .i_sync_bias(i_sync_bias), .o_sync_done(o_sync_done),
    .o_mem_enable(o_mem_enable), .o_rw_mem(o_rw_mem), .o_update_weight(o_update_weight),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_weight(o_mem_weight),
    .o_mem_bias(o_mem_bias), .o_busy(o_busy)
  );

  typedef struct packed {
    logic          rw;
    logic          upd;
    logic [MW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW*NP-1:0] weight;
    logic [DW-1:0] bias;
  } cmd_t;

  typedef struct packed {
    logic [MW-1:0] addr;
    logic          last;
    logic          done;
  } rd_t;

  typedef struct packed {
    logic [MW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_err;
    logic          exp_en;
  } wr_vec_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic rw, input logic upd, input logic [MW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW*NP-1:0] w,
                          input logic [DW-1:0] b);
    cmd_t c;
    c.rw = rw; c.upd = upd; c.addr = a; c.data = d; c.weight = w; c.bias = b;
    cmd_q.push_back(c);
  endtask

  task automatic push_sweep();
    rd_t r;
    for (int a = 0; a < N; a++) begin
      push_cmd(1'b1, 1'b0, MW'(a), '0, '0, '0);
      r.addr = MW'(a); r.last = (a == N-1); r.done = (a == N-1);
      rd_q.push_back(r);
    end
  endtask

  // Scoreboard: every visible command and read beat is matched in order.
  always @(negedge clk) begin
    cmd_t act_c, exp_c;
    rd_t  act_r, exp_r;
    if (rst_n && mon_en) begin
      if (o_mem_enable) begin
        act_c = {o_rw_mem, o_update_weight, o_mem_addr, o_mem_data, o_mem_weight, o_mem_bias};
        if (cmd_q.size() == 0) chk("unexpected_cmd", 160'(act_c), '0);
        else begin
          exp_c = cmd_q.pop_front();
          chk("mem_cmd", 160'(act_c), 160'(exp_c));
        end
      end
      if (o_rd_valid) begin
        act_r = {o_rd_addr, o_rd_last, o_rd_done};
        if (rd_q.size() == 0) chk("unexpected_rd", 160'(act_r), '0);
        else begin
          exp_r = rd_q.pop_front();
          chk("rd_beat", 160'(act_r), 160'(exp_r));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wr_vec_t wr_tbl[5];
    logic sync_pat[12];
    logic prev, v, seen;
    logic [DW*NP-1:0] w;
    logic [DW-1:0] bi;
    int b, j, done_cnt;

    wr_tbl[0] = '{addr: 4'd7,  data: 32'h3F800000, exp_err: 1'b0, exp_en: 1'b1};
    wr_tbl[1] = '{addr: 4'd8,  data: 32'hDEADBEEF, exp_err: 1'b1, exp_en: 1'b0};
    wr_tbl[2] = '{addr: 4'd0,  data: 32'h12345678, exp_err: 1'b0, exp_en: 1'b1};
    wr_tbl[3] = '{addr: 4'd15, data: 32'h0BADF00D, exp_err: 1'b1, exp_en: 1'b0};
    wr_tbl[4] = '{addr: 4'd5,  data: 32'hCAFEF00D, exp_err: 1'b0, exp_en: 1'b1};
    sync_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; i_rd_req = 1'b0; i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_sync_req = 1'b0; i_sync_valid = 1'b0; i_sync_weight = '0; i_sync_bias = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_en", o_mem_enable, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_rd_done", o_rd_done, 0);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_sync_ready", o_sync_ready, 0);
    chk("rst_sync_done", o_sync_done, 0);
    chk("rst_wr_err", o_wr_err, 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_ready", o_wr_ready, 1);

    // Table-driven single writes
    for (int i = 0; i < 5; i++) begin
      cyc();
      i_wr_valid = 1'b1; i_wr_addr = wr_tbl[i].addr; i_wr_data = wr_tbl[i].data;
      if (!wr_tbl[i].exp_err) push_cmd(1'b0, 1'b0, wr_tbl[i].addr, wr_tbl[i].data, '0, '0);
      @(negedge clk);
      chk("wr_ready", o_wr_ready, 1);
      cyc();
      i_wr_valid = 1'b0;
      @(negedge clk);
      chk("wr_err", o_wr_err, wr_tbl[i].exp_err);
      chk("wr_en", o_mem_enable, wr_tbl[i].exp_en);
      chk("wr_busy", o_busy, 1);
      cyc();
      @(negedge clk);
      chk("wr_err_pulse", o_wr_err, 0);
      chk("wr_idle", o_busy, 0);
    end

    // Full read sweep with a write held pending during it
    cyc();
    i_rd_req = 1'b1;
    push_sweep();
    @(negedge clk);
    chk("rd_grant_idle", o_busy, 0);
    for (int k = 1; k <= N + 1; k++) begin
      cyc();
      if (k == 1) begin
        i_wr_valid = 1'b1; i_wr_addr = 4'd2; i_wr_data = 32'h55AA0002;
        push_cmd(1'b0, 1'b0, 4'd2, 32'h55AA0002, '0, '0);
      end
      if (k == N + 1) i_rd_req = 1'b0;
      @(negedge clk);
      chk("rd_wr_ready", o_wr_ready, 0);
      chk("rd_cmd_en", o_mem_enable, (k <= N));
      if (k <= N) chk("rd_cmd_addr", o_mem_addr, MW'(k - 1));
      chk("rd_valid_lag", o_rd_valid, (k >= 2));
      chk("rd_done_time", o_rd_done, (k == N + 1));
    end
    cyc();
    @(negedge clk);
    chk("rd_end_idle", o_busy, 0);
    chk("rd_end_wr_ready", o_wr_ready, 1);
    cyc();
    i_wr_valid = 1'b0;
    @(negedge clk);
    chk("rd_pending_wr_en", o_mem_enable, 1);

    // Reset in the middle of a sweep (cnt=5)
    cyc();
    cyc();
    i_rd_req = 1'b1;
    push_sweep();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 6) begin
        rst_n = 1'b0;
        i_rd_req = 1'b0;
      end
      @(negedge clk);
      if (k < 6) chk("mid_rd_addr", o_mem_addr, MW'(k - 1));
    end
    chk("mid_rst_en", o_mem_enable, 0);
    chk("mid_rst_valid", o_rd_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_addr", o_mem_addr, 0);
    chk("mid_rst_cmd_left", cmd_q.size(), 3);
    chk("mid_rst_rd_left", rd_q.size(), 4);
    cmd_q.delete();
    rd_q.delete();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_rst_busy", o_busy, 0);
      chk("after_rst_rd_done", o_rd_done, 0);
      chk("after_rst_en", o_mem_enable, 0);
      cyc();
    end

    // Sync, write and read requested together; sync beats with gaps
    i_sync_req = 1'b1; i_rd_req = 1'b1;
    i_wr_valid = 1'b1; i_wr_addr = 4'd1; i_wr_data = 32'hA5A50001;
    @(negedge clk);
    chk("prio_wr_ready_blocked", o_wr_ready, 0);
    b = 0; j = 0; prev = 1'b0; done_cnt = 0;
    while (b < N && j < 24) begin
      cyc();
      v = (j < 12) ? sync_pat[j] : 1'b1;
      i_sync_valid = v;
      if (v) begin
        w  = {$urandom, $urandom};
        bi = $urandom;
        i_sync_weight = w; i_sync_bias = bi;
        push_cmd(1'b0, 1'b1, MW'(b), '0, w, bi);
      end
      @(negedge clk);
      chk("sync_ready", o_sync_ready, 1);
      chk("sync_wr_ready", o_wr_ready, 0);
      chk("sync_gap_en", o_mem_enable, prev);
      done_cnt += int'(o_sync_done);
      prev = v;
      if (v) b++;
      j++;
    end
    chk("sync_beats", b, N);
    cyc();
    i_sync_valid = 1'b0;
    @(negedge clk);
    chk("sync_drain_ready", o_sync_ready, 0);
    chk("sync_last_en", o_mem_enable, 1);
    chk("sync_drain_wr_ready", o_wr_ready, 0);
    done_cnt += int'(o_sync_done);
    cyc();
    i_sync_req = 1'b0;
    push_cmd(1'b0, 1'b0, 4'd1, 32'hA5A50001, '0, '0);
    @(negedge clk);
    chk("sync_done_pulse", o_sync_done, 1);
    chk("sync_done_idle", o_busy, 0);
    chk("prio_wr_ready", o_wr_ready, 1);
    done_cnt += int'(o_sync_done);
    cyc();
    i_wr_valid = 1'b0;
    push_sweep();
    @(negedge clk);
    chk("prio_write_en", o_mem_enable, 1);
    done_cnt += int'(o_sync_done);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc();
      @(negedge clk);
      done_cnt += int'(o_sync_done);
      if (o_rd_done) seen = 1'b1;
    end
    chk("prio_rd_done", seen, 1);
    i_rd_req = 1'b0;
    chk("sync_done_once", done_cnt, 1);

    repeat (3) cyc();
    @(negedge clk);
    chk("end_idle", o_busy, 0);
    chk("end_cmd_q_empty", cmd_q.size(), 0);
    chk("end_rd_q_empty", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
